// File: rtl/n101_regvec_change_reader_if.sv
// Bundles the sampled-vector input, the record drain handshake and the status outputs of
// n101_regvec_change_reader.
interface n101_regvec_change_reader_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) ();
  logic [WIDTH-1:0] io_q;
  logic             io_sample_en;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_value;
  logic [WIDTH-1:0] io_out_mask;
  logic             io_overflow;
  logic             io_overflow_clr;
  logic [CNT_W-1:0] io_count;

  // Driver/consumer side.
  modport master (
    output io_q, io_sample_en, io_out_ready, io_overflow_clr,
    input  io_out_valid, io_out_value, io_out_mask, io_overflow, io_count
  );

  // Change-reader side.
  modport slave (
    input  io_q, io_sample_en, io_out_ready, io_overflow_clr,
    output io_out_valid, io_out_value, io_out_mask, io_overflow, io_count
  );
endinterface

// File: rtl/n101_regvec_change_reader.sv
// Samples a register vector, detects changes and queues {value, changed-bit mask} records in a
// small FIFO; a full FIFO coalesces new changes into the tail record and sets a sticky overflow.
module n101_regvec_change_reader #(
  parameter int unsigned      WIDTH     = 3,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 8
) (
  input logic                    clock,
  input logic                    reset,
  n101_regvec_change_reader_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] OccFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] val_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [AW:0]      occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             chg, full, pop, push, coalesce;
  logic [WIDTH-1:0] xm;

  always_comb begin
    chg      = bus.io_sample_en && (bus.io_q != prev_q);
    xm       = bus.io_q ^ prev_q;
    full     = (occ_q == OccFull);
    pop      = (occ_q != '0) && bus.io_out_ready;
    // A pop on a full FIFO frees the head slot this edge, so the push is a normal write.
    push     = chg && (!full || pop);
    coalesce = chg && full && !pop;
    tail_ptr = wr_ptr_q - 1'b1;

    prev_d   = chg ? bus.io_q : prev_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end

    // Set wins over clear.
    ovf_d = ovf_q;
    if (coalesce) begin
      ovf_d = 1'b1;
    end else if (bus.io_overflow_clr) begin
      ovf_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (chg && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= RESET_VAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        val_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      if (push) begin
        val_q[wr_ptr_q]  <= bus.io_q;
        mask_q[wr_ptr_q] <= xm;
      end else if (coalesce) begin
        val_q[tail_ptr]  <= bus.io_q;
        mask_q[tail_ptr] <= mask_q[tail_ptr] | xm;
      end
    end
  end

  assign bus.io_out_valid = (occ_q != '0);
  assign bus.io_out_value = bus.io_out_valid ? val_q[rd_ptr_q] : '0;
  assign bus.io_out_mask  = bus.io_out_valid ? mask_q[rd_ptr_q] : '0;
  assign bus.io_overflow  = ovf_q;
  assign bus.io_count     = cnt_q;

endmodule
